// File: rtl/inst_encoder_if.sv
// Field-tuple input stream and encoded-word output stream of the instruction encoder.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded instruction fields into RV32 words and streams them, with
// word addresses, to an instruction-memory write port.
//
// state | meaning
// IDLE  | waiting for start; no tuples accepted
// RUN   | accepting tuples and emitting encoded words
// DONE  | last word handed off; done pulses for one cycle
module inst_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    inst_encoder_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0]    FMT_R     = 2'b00;
    localparam logic [1:0]    FMT_I     = 2'b01;
    localparam logic [1:0]    FMT_S     = 2'b10;
    localparam logic [6:0]    OP_OP     = 7'b0110011;
    localparam logic [6:0]    OP_STORE  = 7'b0100011;
    localparam logic [6:0]    OP_BRANCH = 7'b1100011;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   acc_rem;
    logic [ADDR_W:0]   out_rem;
    logic              out_valid_q;
    logic [31:0]       out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic              in_ready_c;
    logic              in_fire;
    logic              out_fire;
    logic              start_ok;
    logic [31:0]       enc_word;
    logic              enc_err;
    logic              imm_wide;

    assign start_ok = (state == IDLE) && start;
    assign in_fire  = bus.in_valid && in_ready_c;
    assign out_fire = out_valid_q && bus.out_ready;

    // Encode the presented tuple and flag out-of-range immediates / illegal I opcodes.
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        imm_wide = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
        case (bus.fmt)
            FMT_R: begin
                enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_OP};
            end
            FMT_I: begin
                enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_err  = imm_wide || (bus.opcode == OP_STORE) || (bus.opcode == OP_BRANCH);
            end
            FMT_S: begin
                enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OP_STORE};
                enc_err  = imm_wide;
            end
            default: begin
                // imm is already a halfword offset, so bit k of imm is bit k+1 of the byte offset
                enc_word = {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[3:0], bus.imm[10], OP_BRANCH};
                enc_err  = imm_wide;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                in_ready_c = (acc_rem != '0) && (!out_valid_q || bus.out_ready);
                if (out_fire && (out_rem == CNT_ONE)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/remaining counters, output register and sticky error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt    <= '0;
            acc_rem     <= '0;
            out_rem     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            if (start_ok) begin
                addr_cnt   <= base_addr;
                acc_rem    <= len;
                out_rem    <= len;
                err_q      <= 1'b0;
                err_addr_q <= '0;
            end
            if (in_fire) begin
                out_data_q <= enc_word;
                out_addr_q <= addr_cnt;
                addr_cnt   <= addr_cnt + 1'b1;
                acc_rem    <= acc_rem - 1'b1;
                if (enc_err) begin
                    err_q <= 1'b1;
                    if (!err_q) begin
                        err_addr_q <= addr_cnt;
                    end
                end
            end
            if (out_fire) begin
                out_rem <= out_rem - 1'b1;
            end
            if (in_fire) begin
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign err           = err_q;
    assign err_addr      = err_addr_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: scoreboard of expected words/addresses
// filled on input acceptance and drained by a monitor on output handshakes.
module tb_inst_encoder;
    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [31:0]       data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    int                tests_run    = 0;
    int                tests_failed = 0;
    int                cyc          = 0;
    exp_t              sb[$];
    exp_t              mon_e;
    logic [ADDR_W-1:0] tb_addr;
    bit                err_seen;
    logic [ADDR_W-1:0] err_first;
    bit                rand_rdy = 1'b0;

    // Free-running cycle count for throughput measurement.
    always @(posedge clk) cyc++;

    // Random output back-pressure while enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Drain the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_underflow: got %h@%h with nothing expected", bus.out_data, bus.out_addr);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_data !== mon_e.data || bus.out_addr !== mon_e.addr) begin
                    tests_failed++;
                    $display("FAIL word: got %h@%h required %h@%h", bus.out_data, bus.out_addr, mon_e.data, mon_e.addr);
                end
            end
        end
    end

    function automatic logic [31:0] model_word(input logic [1:0] f, input logic [6:0] op,
                                               input logic [4:0] rd_v, input logic [4:0] rs1_v,
                                               input logic [4:0] rs2_v, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] imm_v);
        logic [31:0] w;
        w = (32'(rs1_v) << 15) | (32'(f3) << 12);
        case (f)
            2'd0: w = w | (32'(f7) << 25) | (32'(rs2_v) << 20) | (32'(rd_v) << 7) | 32'h33;
            2'd1: w = w | ((imm_v & 32'hFFF) << 20) | (32'(rd_v) << 7) | 32'(op);
            2'd2: w = w | (((imm_v >> 5) & 32'h7F) << 25) | (32'(rs2_v) << 20)
                        | ((imm_v & 32'h1F) << 7) | 32'h23;
            default: w = w | (((imm_v >> 11) & 32'h1) << 31) | (((imm_v >> 4) & 32'h3F) << 25)
                           | (32'(rs2_v) << 20) | ((imm_v & 32'hF) << 8)
                           | (((imm_v >> 10) & 32'h1) << 7) | 32'h63;
        endcase
        return w;
    endfunction

    function automatic bit model_err(input logic [1:0] f, input logic [6:0] op, input logic [31:0] imm_v);
        if (f == 2'd0) return 1'b0;
        if ($signed(imm_v) > 2047 || $signed(imm_v) < -2048) return 1'b1;
        if (f == 2'd1 && (op == 7'h23 || op == 7'h63)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        tb_addr   = b;
        err_seen  = 1'b0;
        err_first = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one tuple and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd_v,
                        input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm_v, input logic [31:0] exp_word);
        bit acc = 1'b0;
        bus.fmt = f; bus.opcode = op; bus.rd = rd_v; bus.rs1 = rs1_v; bus.rs2 = rs2_v;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm_v; bus.in_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                sb.push_back({exp_word, tb_addr});
                if (model_err(f, op, imm_v) && !err_seen) begin
                    err_seen  = 1'b1;
                    err_first = tb_addr;
                end
                tb_addr = tb_addr + 1'b1;
                acc     = 1'b1;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (!acc) begin
            tests_failed++;
            $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", bus.in_ready);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_addr !== '0 ||
            bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_data !== '0 || bus.out_addr !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b err=%b err_addr=%h ov=%b ir=%b od=%h oa=%h required all 0",
                     busy, done, err, err_addr, bus.out_valid, bus.in_ready, bus.out_data, bus.out_addr);
        end
    endtask

    task automatic test_single;
        bit got;
        bus.out_ready = 1'b1;
        do_start(10'd0, 11'd1);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL single_busy: got %b required 1", busy);
        end
        send(2'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093);
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00500093 || bus.out_addr !== 10'd0) begin
            tests_failed++;
            $display("FAIL single_latency: got v=%b %h@%h required v=1 00500093@000", bus.out_valid, bus.out_data, bus.out_addr);
        end
        wait_done(got);
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL single_done: got no done required pulse"); end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL single_end: done=%b busy=%b err=%b pending=%0d required 0 0 0 0", done, busy, err, sb.size());
        end
    endtask

    task automatic test_wrap;
        bit got;
        do_start(10'h3FE, 11'd3);
        send(2'd2, 7'd0, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423);
        send(2'd3, 7'd0, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFE, 32'hFE208EE3);
        send(2'd0, 7'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 32'h002081B3);
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_addr !== 10'h000 || bus.out_data !== 32'h002081B3) begin
            tests_failed++;
            $display("FAIL wrap_addr: got %h@%h required 002081b3@000", bus.out_data, bus.out_addr);
        end
        wait_done(got);
        @(posedge clk); #1;
        tests_run++;
        if (!got || sb.size() != 0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_end: done_seen=%b pending=%0d err=%b required 1 0 0", got, sb.size(), err);
        end
    endtask

    task automatic test_stall_throughput;
        bit got;
        logic [31:0]       hold_d;
        logic [ADDR_W-1:0] hold_a;
        int c0;
        int c1;
        do_start(10'd20, 11'd6);
        send(2'd0, 7'd0, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0, model_word(2'd0, 7'd0, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0));
        send(2'd1, 7'h03, 5'd7, 5'd8, 5'd0, 3'd2, 7'd0, 32'd100, model_word(2'd1, 7'h03, 5'd7, 5'd8, 5'd0, 3'd2, 7'd0, 32'd100));
        bus.fmt = 2'd2; bus.rs1 = 5'd9; bus.rs2 = 5'd10; bus.funct3 = 3'd1; bus.imm = 32'hFFFFFFF0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        hold_d = bus.out_data;
        hold_a = bus.out_addr;
        tests_run++;
        if (hold_a !== 10'd21) begin
            tests_failed++; $display("FAIL stall_addr: got %h required 015", hold_a);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== hold_d || bus.out_addr !== hold_a) begin
                tests_failed++;
                $display("FAIL stall_hold: ir=%b ov=%b %h@%h required 0 1 %h@%h",
                         bus.in_ready, bus.out_valid, bus.out_data, bus.out_addr, hold_d, hold_a);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send(2'd2, 7'd0, 5'd0, 5'd9, 5'd10, 3'd1, 7'd0, 32'hFFFFFFF0, model_word(2'd2, 7'd0, 5'd0, 5'd9, 5'd10, 3'd1, 7'd0, 32'hFFFFFFF0));
        c0 = cyc;
        send(2'd3, 7'd0, 5'd0, 5'd11, 5'd12, 3'd5, 7'd0, 32'd300, model_word(2'd3, 7'd0, 5'd0, 5'd11, 5'd12, 3'd5, 7'd0, 32'd300));
        send(2'd0, 7'd0, 5'd13, 5'd14, 5'd15, 3'd0, 7'h01, 32'd0, model_word(2'd0, 7'd0, 5'd13, 5'd14, 5'd15, 3'd0, 7'h01, 32'd0));
        send(2'd1, 7'h13, 5'd16, 5'd17, 5'd0, 3'd4, 7'd0, 32'hFFFFF800, model_word(2'd1, 7'h13, 5'd16, 5'd17, 5'd0, 3'd4, 7'd0, 32'hFFFFF800));
        c1 = cyc;
        bus.in_valid = 1'b0;
        tests_run++;
        if (c1 - c0 != 3) begin
            tests_failed++; $display("FAIL throughput: got %0d cycles for 3 words required 3", c1 - c0);
        end
        wait_done(got);
        @(posedge clk); #1;
        tests_run++;
        if (!got || sb.size() != 0) begin
            tests_failed++; $display("FAIL stall_end: done_seen=%b pending=%0d required 1 0", got, sb.size());
        end
    endtask

    task automatic test_err;
        bit got;
        do_start(10'd4, 11'd4);
        send(2'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd2048, model_word(2'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd2048));
        tests_run++;
        if (err !== 1'b1 || err_addr !== 10'd4) begin
            tests_failed++; $display("FAIL err_first: got err=%b addr=%h required 1 004", err, err_addr);
        end
        send(2'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, model_word(2'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFF000));
        send(2'd1, 7'h23, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, model_word(2'd1, 7'h23, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0));
        send(2'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, model_word(2'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800));
        bus.in_valid = 1'b0;
        wait_done(got);
        @(posedge clk); #1;
        tests_run++;
        if (!got || err !== 1'b1 || err_addr !== 10'd4 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL err_sticky: done_seen=%b err=%b addr=%h pending=%0d required 1 1 004 0", got, err, err_addr, sb.size());
        end
        do_start(10'd7, 11'd3);
        tests_run++;
        if (err !== 1'b0 || err_addr !== '0) begin
            tests_failed++; $display("FAIL err_clear: got err=%b addr=%h required 0 000", err, err_addr);
        end
        send(2'd0, 7'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h12345678, model_word(2'd0, 7'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h12345678));
        send(2'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2047, model_word(2'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2047));
        send(2'd2, 7'd0, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFF800, model_word(2'd2, 7'd0, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFF800));
        bus.in_valid = 1'b0;
        wait_done(got);
        @(posedge clk); #1;
        tests_run++;
        if (!got || err !== 1'b0) begin
            tests_failed++; $display("FAIL err_inrange: done_seen=%b err=%b required 1 0", got, err);
        end
    endtask

    task automatic test_len0_and_ignore;
        bit got;
        do_start(10'd0, 11'd0);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL len0_done: done=%b busy=%b ir=%b required 1 0 0", done, busy, bus.in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL len0_pulse: done=%b required 0", done);
        end
        do_start(10'd100, 11'd2);
        send(2'd0, 7'd0, 5'd1, 5'd1, 5'd1, 3'd1, 7'd0, 32'd0, model_word(2'd0, 7'd0, 5'd1, 5'd1, 5'd1, 3'd1, 7'd0, 32'd0));
        bus.in_valid = 1'b0;
        start = 1'b1; base_addr = 10'd300; len = 11'd0;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++; $display("FAIL start_ignored: busy=%b done=%b required 1 0", busy, done);
        end
        send(2'd3, 7'd0, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'd2047, model_word(2'd3, 7'd0, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'd2047));
        bus.in_valid = 1'b0;
        wait_done(got);
        @(posedge clk); #1;
        tests_run++;
        if (!got || sb.size() != 0) begin
            tests_failed++; $display("FAIL ignore_end: done_seen=%b pending=%0d required 1 0", got, sb.size());
        end
    endtask

    task automatic test_random;
        bit got;
        logic [1:0]  f;
        logic [6:0]  op;
        logic [4:0]  r0, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] t;
        logic [31:0] iv;
        do_start(10'($urandom_range(0, 1023)), 11'd12);
        rand_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            f  = 2'($urandom_range(0, 3));
            op = 7'($urandom_range(0, 127));
            r0 = 5'($urandom_range(0, 31));
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'($urandom_range(0, 127));
            t  = 12'($urandom_range(0, 4095));
            iv = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {{20{t[11]}}, t};
            send(f, op, r0, r1, r2, f3, f7, iv, model_word(f, op, r0, r1, r2, f3, f7, iv));
        end
        bus.in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        wait_done(got);
        @(posedge clk); #1;
        tests_run++;
        if (!got || sb.size() != 0 || err !== err_seen || (err_seen && err_addr !== err_first)) begin
            tests_failed++;
            $display("FAIL random: done_seen=%b pending=%0d err=%b addr=%h required 1 0 %b %h",
                     got, sb.size(), err, err_addr, err_seen, err_first);
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        do_start(10'd50, 11'd4);
        bus.out_ready = 1'b0;
        send(2'd0, 7'd0, 5'd2, 5'd3, 5'd4, 3'd0, 7'd0, 32'd0, model_word(2'd0, 7'd0, 5'd2, 5'd3, 5'd4, 3'd0, 7'd0, 32'd0));
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: ov=%b busy=%b ir=%b required 0 0 0", bus.out_valid, busy, bus.in_ready);
        end
        sb.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_idle: busy=%b done=%b ov=%b required 0 0 0", busy, done, bus.out_valid);
        end
        do_start(10'd9, 11'd1);
        send(2'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1, model_word(2'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1));
        bus.in_valid = 1'b0;
        wait_done(got);
        @(posedge clk); #1;
        tests_run++;
        if (!got || sb.size() != 0 || err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_reload: done_seen=%b pending=%0d err=%b required 1 0 0", got, sb.size(), err);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        bus.in_valid = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0;
        bus.rs2 = '0; bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0; bus.out_ready = 1'b1;
        tb_addr = '0; err_seen = 1'b0; err_first = '0;
        #22;
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_wrap();
        test_stall_throughput();
        test_err();
        test_len0_and_ignore();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Packs decoded instruction fields (format, registers, functs, 32-bit immediate) into RV32 instruction words.
- Streams the words, with word addresses, to an instruction-memory write port.
- Used by the bench loader and the debug path to build program images in hardware.
- Inverse of the core's immediate generator. Round trip is exact: for any in-range imm, the generator's output on the encoded word equals sign-extend-12 of imm.
- B-type imm uses the same halfword-offset convention as the generator (imm = byte offset / 2).

Parameters:
- ADDR_W, 10, width of the word address and the program length.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a program load; honoured only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled on an accepted start.
- len  in  ADDR_W+1  number of words in the program; sampled on an accepted start.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept a field tuple.
- fmt  in  2  00=R, 01=I, 10=S, 11=B.
- opcode  in  7  used for I format only.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  used for R format only.
- imm  in  32  signed immediate; B format is a halfword offset.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  memory port accepts the word.
- out_data  out  32  encoded instruction word.
- out_addr  out  ADDR_W  word address of out_data.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the last word handshakes.
- err  out  1  sticky error; cleared by the next accepted start.
- err_addr  out  ADDR_W  address of the first erroneous word.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst_n is asynchronous, active-low.
  - Reset forces IDLE and clears all counters. All outputs reset to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: capture base_addr into the address counter, capture len into the remaining counter, clear err and err_addr.
  - Next state: DONE if len==0, else RUN.
- RUN:
  - busy=1.
  - start is ignored.
  - in_ready = (accepted count < len) && (!out_valid || out_ready).
- Input handshake and latency:
  - A tuple is accepted when in_valid && in_ready.
  - The encoded word appears on out_data and out_valid on the next cycle (latency 1), registered.
  - out_data and out_addr hold stable while out_valid && !out_ready.
  - Accept and output handshake may occur in the same cycle, giving full throughput.
- Addressing:
  - out_addr = base_addr + index of the word, modulo 2^ADDR_W.
  - Wrap-around is silent.
- Completion:
  - When the output handshake for word len-1 completes: go to DONE.
  - DONE pulses done=1 for one cycle, then returns to IDLE.
- Encoding (i = imm):
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}; imm is ignored.
  - I: {i[11:0], rs1, funct3, rd, opcode}.
  - S: {i[11:5], rs2, rs1, funct3, i[4:0], 7'b0100011}.
  - B: {i[11], i[9:4], rs2, rs1, funct3, i[3:0], i[10], 7'b1100011}.
- Errors:
  - Error conditions:
    - For I/S/B, imm[31:11] is not all equal (out of 12-bit signed range).
    - For I, opcode equals 0100011 or 1100011.
  - On error the word is still emitted with the truncated immediate.
  - err is set. err_addr captures the word address only if err was previously 0.
- Reset mid-RUN: pending output is dropped, counters are cleared, state returns to IDLE.

Test Plan:
- start base=0, len=1; I tuple opcode=0010011, rd=1, rs1=0, f3=0, imm=5 -> out_data=0x00500093, out_addr=0, valid one cycle after accept; done pulses; err=0.
- len=3 at base=0x3FE with S (rs2=2, rs1=1, f3=010, imm=8), B (rs1=1, rs2=2, f3=000, imm=0xFFFFFFFE), R (rd=3, rs1=1, rs2=2, f3=0, f7=0) -> 0x0020A423@0x3FE, 0xFE208EE3@0x3FF, 0x002081B3@0x000 (wrap).
- out_ready held low 5 cycles mid-stream -> in_ready=0, out_data/out_addr stable; with continuous valid/ready, one word per cycle.
- I imm=2048 at base=4, then I imm=-4096 -> err=1, err_addr=4 (first error kept), words still emitted; next start clears err.
- start with len=0 -> no in_ready, done pulse 1 cycle after start; start during RUN ignored.
- rst_n low mid-RUN while out_valid=1 -> out_valid=0, busy=0 immediately (asynchronous); FSM in IDLE.
